// File: rtl/usb_rx_ram_writer_if.sv
// Byte stream in / RAM port-2 out bundle for usb_rx_ram_writer.
// master: byte source and RAM observer; slave: the writer block.
interface usb_rx_ram_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_eop;
  logic        in_ready;
  logic [10:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;

  modport master (
    output in_data, in_valid, in_eop,
    input  in_ready,
    input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata
  );

  modport slave (
    input  in_data, in_valid, in_eop,
    output in_ready,
    output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata
  );
endinterface

// File: rtl/usb_rx_ram_writer.sv
// usb_rx_ram_writer: packs the USB RX byte stream little-endian into 32-bit
// words, writes them into a circular region of the RX RAM (port 2) and posts a
// {pkt_count, pkt_len} status word at STATUS_ADDR at the end of every packet.
// Optional build macro USB_RX_OVERFLOW_DROP_EN: instead of back-pressuring while
// the ring is full, accept and discard bytes and count them in overflow_cnt.
module usb_rx_ram_writer #(
  parameter int unsigned PTR_W       = 10,
  parameter int unsigned STATUS_ADDR = 1024,
  parameter int unsigned LEN_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  usb_rx_ram_writer_if.slave  bus,
  input  logic [PTR_W-1:0]    cpu_rd_ptr,
  output logic [PTR_W-1:0]    wr_ptr,
  output logic [PTR_W:0]      level,
  output logic                pkt_done,
  output logic [15:0]         overflow_cnt
);

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEPTH  = 1 << PTR_W;

  localparam logic [PTR_W:0]  FULL_LEVEL = (PTR_W+1)'(DEPTH - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = {LEN_W{1'b1}};

  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_STAT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              last_q, last_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [BE_W-1:0]   ram_be_q, ram_be_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wd_q, ram_wd_d;
  logic              pkt_done_q, pkt_done_d;

  logic [PTR_W:0]    level_c;
  logic              full_c;
  logic              in_ready_c;
  logic              accept_c;

`ifdef USB_RX_OVERFLOW_DROP_EN
  logic [15:0]       ovf_q, ovf_d;
`endif

  // Ring occupancy, full flag and input handshake.
  always_comb begin
    level_c = {1'b0, PTR_W'(wr_ptr_q - cpu_rd_ptr)};
    full_c  = (level_c == FULL_LEVEL);
`ifdef USB_RX_OVERFLOW_DROP_EN
    in_ready_c = enable & (state_q == ACCUM);
`else
    in_ready_c = enable & (state_q == ACCUM) & ~full_c;
`endif
    accept_c = bus.in_valid & in_ready_c;
  end

  // Next-state, packing and registered RAM-port values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pack_d     = pack_q;
    be_d       = be_q;
    last_d     = last_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    pkt_done_d = 1'b0;
    ram_addr_d = '0;
    ram_be_d   = '0;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_wd_d   = '0;
`ifdef USB_RX_OVERFLOW_DROP_EN
    ovf_d      = ovf_q;
`endif

    case (state_q)
      ACCUM: begin
        if (accept_c) begin
`ifdef USB_RX_OVERFLOW_DROP_EN
          if (full_c) begin
            // Dropped byte: count it; a dropped eop still closes the packet.
            if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
            if (bus.in_eop) begin
              last_d  = 1'b1;
              state_d = WR_STAT;
            end
          end else
`endif
          begin
            pack_d = pack_q | (DATA_W'({24'd0, bus.in_data}) << {idx_q, 3'b000});
            be_d   = be_q | (BE_W'(1) << idx_q);
            if (len_q != LEN_MAX) len_d = len_q + LEN_W'(1);
            if ((idx_q == 2'd3) || bus.in_eop) begin
              last_d  = bus.in_eop;
              state_d = WR_DATA;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
      end
      WR_DATA: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        idx_d    = '0;
        pack_d   = '0;
        be_d     = '0;
        state_d  = last_q ? WR_STAT : ACCUM;
      end
      WR_STAT: begin
        cnt_d      = cnt_q + CNT_W'(1);
        len_d      = '0;
        last_d     = 1'b0;
        idx_d      = '0;
        pack_d     = '0;
        be_d       = '0;
        pkt_done_d = 1'b1;
        state_d    = ACCUM;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    // RAM port values are registered so they line up with the write state.
    if (state_d == WR_DATA) begin
      ram_cs_d   = 1'b1;
      ram_we_d   = 1'b1;
      ram_addr_d = ADDR_W'(wr_ptr_q);
      ram_be_d   = be_d;
      ram_wd_d   = pack_d;
    end else if (state_d == WR_STAT) begin
      ram_cs_d   = 1'b1;
      ram_we_d   = 1'b1;
      ram_addr_d = ADDR_W'(STATUS_ADDR);
      ram_be_d   = 4'hF;
      ram_wd_d   = {cnt_q + CNT_W'(1), 16'(len_d)};
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACCUM;
      idx_q      <= '0;
      pack_q     <= '0;
      be_q       <= '0;
      last_q     <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      ram_addr_q <= '0;
      ram_be_q   <= '0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_wd_q   <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pack_q     <= pack_d;
      be_q       <= be_d;
      last_q     <= last_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      ram_addr_q <= ram_addr_d;
      ram_be_q   <= ram_be_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_wd_q   <= ram_wd_d;
      pkt_done_q <= pkt_done_d;
    end
  end

`ifdef USB_RX_OVERFLOW_DROP_EN
  // Dropped-byte counter; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end
  assign overflow_cnt = ovf_q;
`else
  assign overflow_cnt = '0;
`endif

  assign bus.in_ready       = in_ready_c;
  assign bus.ram_address    = ram_addr_q;
  assign bus.ram_byteenable = ram_be_q;
  assign bus.ram_chipselect = ram_cs_q;
  assign bus.ram_write      = ram_we_q;
  assign bus.ram_writedata  = ram_wd_q;
  assign wr_ptr             = wr_ptr_q;
  assign level              = level_c;
  assign pkt_done           = pkt_done_q;

endmodule

// File: tb/tb_usb_rx_ram_writer.sv
// Directed bench for usb_rx_ram_writer: per-cycle vector table plus hand
// sequences for ring fill / wrap and the optional drop mode.
module tb_usb_rx_ram_writer;

  localparam int unsigned PTR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [PTR_W-1:0]  cpu_rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    level;
  logic              pkt_done;
  logic [15:0]       overflow_cnt;

  usb_rx_ram_writer_if bus();

  usb_rx_ram_writer #(.PTR_W(PTR_W), .STATUS_ADDR(1024), .LEN_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bus          (bus.slave),
    .cpu_rd_ptr   (cpu_rd_ptr),
    .wr_ptr       (wr_ptr),
    .level        (level),
    .pkt_done     (pkt_done),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM write observer.
  int          data_wr_cnt = 0;
  int          stat_wr_cnt = 0;
  logic [10:0] last_data_addr = '0;
  logic [31:0] last_stat_data = '0;

  always @(negedge clk) begin
    if (reset !== 1'b1 && bus.ram_write === 1'b1) begin
      if (bus.ram_address == 11'd1024) begin
        stat_wr_cnt++;
        last_stat_data = bus.ram_writedata;
      end else begin
        data_wr_cnt++;
        last_data_addr = bus.ram_address;
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic        valid;
    logic        eop;
    logic [7:0]  data;
    logic        exp_ready;
    logic        exp_write;
    logic [10:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_done;
    logic [9:0]  exp_ptr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic v, input logic p,
                              input logic [7:0] d, input logic rdy, input logic wr,
                              input logic [10:0] a, input logic [31:0] wd, input logic [3:0] be,
                              input logic dn, input logic [9:0] ptr);
    vec_t t;
    t.rst = r; t.en = e; t.valid = v; t.eop = p; t.data = d;
    t.exp_ready = rdy; t.exp_write = wr; t.exp_addr = a; t.exp_wdata = wd;
    t.exp_be = be; t.exp_done = dn; t.exp_ptr = ptr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] d, input logic e, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_data = d; bus.in_valid = 1'b1; bus.in_eop = e;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.in_ready === 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int base_data;
    int base_stat;

    reset = 1'b1; enable = 1'b1; cpu_rd_ptr = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_eop = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    chk("reset wr_ptr",    32'(wr_ptr), 32'd0);
    chk("reset level",     32'(level), 32'd0);
    chk("reset ram_write", 32'(bus.ram_write), 32'd0);
    chk("reset ram_cs",    32'(bus.ram_chipselect), 32'd0);
    chk("reset pkt_done",  32'(pkt_done), 32'd0);
    chk("reset overflow",  32'(overflow_cnt), 32'd0);
    chk("reset in_ready",  32'(bus.in_ready), 32'd1);

    // 8-byte packet, in_valid held through the data write cycles.
    vecs.push_back(mk(0,1,1,0,8'h01, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'h02, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'h03, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'h04, 1,1,11'd0,   32'h04030201, 4'hF,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'h05, 0,0,11'd0,   32'h0,        4'h0,0,10'd1));
    vecs.push_back(mk(0,1,1,0,8'h05, 1,0,11'd0,   32'h0,        4'h0,0,10'd1));
    vecs.push_back(mk(0,1,1,0,8'h06, 1,0,11'd0,   32'h0,        4'h0,0,10'd1));
    vecs.push_back(mk(0,1,1,0,8'h07, 1,0,11'd0,   32'h0,        4'h0,0,10'd1));
    vecs.push_back(mk(0,1,1,1,8'h08, 1,1,11'd1,   32'h08070605, 4'hF,0,10'd1));
    vecs.push_back(mk(0,1,0,0,8'h00, 0,1,11'd1024,32'h00010008, 4'hF,0,10'd2));
    vecs.push_back(mk(0,1,0,0,8'h00, 0,0,11'd0,   32'h0,        4'h0,1,10'd2));
    vecs.push_back(mk(0,1,0,0,8'h00, 1,0,11'd0,   32'h0,        4'h0,0,10'd2));
    // Reset, then a 3-byte packet: partial word with byteenable 0111.
    vecs.push_back(mk(1,1,0,0,8'h00, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'hAA, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'hBB, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,1,8'hCC, 1,1,11'd0,   32'h00CCBBAA, 4'h7,0,10'd0));
    vecs.push_back(mk(0,1,0,0,8'h00, 0,1,11'd1024,32'h00010003, 4'hF,0,10'd1));
    vecs.push_back(mk(0,1,0,0,8'h00, 0,0,11'd0,   32'h0,        4'h0,1,10'd1));
    vecs.push_back(mk(0,1,0,0,8'h00, 1,0,11'd0,   32'h0,        4'h0,0,10'd1));
    // Reset after 2 bytes of a word (byte offered in the reset cycle is lost),
    // enable low mid-word, then a full word at address 0.
    vecs.push_back(mk(0,1,1,0,8'h11, 1,0,11'd0,   32'h0,        4'h0,0,10'd1));
    vecs.push_back(mk(0,1,1,0,8'h22, 1,0,11'd0,   32'h0,        4'h0,0,10'd1));
    vecs.push_back(mk(1,1,1,0,8'h99, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'h41, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'h42, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,0,1,0,8'h77, 0,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'h43, 1,0,11'd0,   32'h0,        4'h0,0,10'd0));
    vecs.push_back(mk(0,1,1,0,8'h44, 1,1,11'd0,   32'h44434241, 4'hF,0,10'd0));
    vecs.push_back(mk(0,1,0,0,8'h00, 0,0,11'd0,   32'h0,        4'h0,0,10'd1));
    // eop without valid is ignored; single-byte packet closes with pkt_len 5.
    vecs.push_back(mk(0,1,0,1,8'hEE, 1,0,11'd0,   32'h0,        4'h0,0,10'd1));
    vecs.push_back(mk(0,1,1,1,8'h55, 1,1,11'd1,   32'h00000055, 4'h1,0,10'd1));
    vecs.push_back(mk(0,1,0,0,8'h00, 0,1,11'd1024,32'h00010005, 4'hF,0,10'd2));
    vecs.push_back(mk(0,1,0,0,8'h00, 0,0,11'd0,   32'h0,        4'h0,1,10'd2));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; enable = vecs[i].en;
      bus.in_valid = vecs[i].valid; bus.in_eop = vecs[i].eop; bus.in_data = vecs[i].data;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ram_write", i), 32'(bus.ram_write), 32'(vecs[i].exp_write));
      chk($sformatf("v%0d ram_cs", i),    32'(bus.ram_chipselect), 32'(vecs[i].exp_write));
      chk($sformatf("v%0d ram_addr", i),  32'(bus.ram_address), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d ram_wdata", i), bus.ram_writedata, vecs[i].exp_wdata);
      chk($sformatf("v%0d ram_be", i),    32'(bus.ram_byteenable), 32'(vecs[i].exp_be));
      chk($sformatf("v%0d pkt_done", i),  32'(pkt_done), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d wr_ptr", i),    32'(wr_ptr), 32'(vecs[i].exp_ptr));
    end

    // Fill the ring: 1023 full words with the consumer parked at 0.
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; bus.in_valid = 1'b0; bus.in_eop = 1'b0; cpu_rd_ptr = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    base_data = data_wr_cnt;
    base_stat = stat_wr_cnt;
    ok = 1'b1;
    for (int w = 0; w < 1023 && ok; w++) begin
      for (int b = 0; b < 4 && ok; b++) send_byte(8'(w + b), 1'b0, ok);
    end
    chk("fill accept timeout", 32'(ok), 32'd1);
    idle(2);
    chk("fill data writes", 32'(data_wr_cnt - base_data), 32'd1023);
    chk("fill last addr",   32'(last_data_addr), 32'd1022);
    chk("fill wr_ptr",      32'(wr_ptr), 32'd1023);
    chk("fill level",       32'(level), 32'd1023);
    chk("fill in_ready",    32'(bus.in_ready), 32'(0));

`ifdef USB_RX_OVERFLOW_DROP_EN
    // Full ring: five bytes, eop last, are dropped; status still written.
    base_data = data_wr_cnt;
    for (int b = 0; b < 5 && ok; b++) send_byte(8'hD0 + 8'(b), (b == 4), ok);
    chk("drop accept timeout", 32'(ok), 32'd1);
    idle(3);
    chk("drop overflow_cnt", 32'(overflow_cnt), 32'd5);
    chk("drop data writes",  32'(data_wr_cnt - base_data), 32'd0);
    chk("drop stat writes",  32'(stat_wr_cnt - base_stat), 32'd1);
    chk("drop status",       last_stat_data, 32'h0001_0FFC);
`else
    // Full ring holds off a waiting byte.
    base_data = data_wr_cnt;
    @(negedge clk);
    bus.in_data = 8'hA0; bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("full hold in_ready %0d", k), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    chk("full hold writes",  32'(data_wr_cnt - base_data), 32'd0);
    chk("overflow tied off", 32'(overflow_cnt), 32'd0);

    // Consumer frees one slot: next word lands at 1023 and wr_ptr wraps.
    cpu_rd_ptr = 10'd1;
    #1;
    chk("free in_ready", 32'(bus.in_ready), 32'd1);
    for (int b = 0; b < 4 && ok; b++) send_byte(8'hA0 + 8'(b), 1'b0, ok);
    chk("wrap accept timeout", 32'(ok), 32'd1);
    idle(2);
    chk("wrap last addr", 32'(last_data_addr), 32'd1023);
    chk("wrap data",      32'(data_wr_cnt - base_data), 32'd1);
    chk("wrap wr_ptr",    32'(wr_ptr), 32'd0);
    chk("wrap level",     32'(level), 32'd1023);
    chk("wrap in_ready",  32'(bus.in_ready), 32'd0);

    // Close the packet: 1024 words + 1 byte -> pkt_len 4097.
    cpu_rd_ptr = 10'd2;
    send_byte(8'hEE, 1'b1, ok);
    chk("close accept timeout", 32'(ok), 32'd1);
    idle(3);
    chk("close last addr", 32'(last_data_addr), 32'd0);
    chk("close stat writes", 32'(stat_wr_cnt - base_stat), 32'd1);
    chk("close status", last_stat_data, 32'h0001_1001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
